// File: rtl/wtch_ctrl_pkg.sv
// Shared types and constants for the watch mode/calibration controller.
// Build option: WTCH_CTRL_AUTOREPEAT_EN enables up/dn auto-repeat in wtch_rpt_pulse.
package wtch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STOP  = 2'd1,
        ST_CALIB = 2'd2
    } state_e;

    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_MODE = 8'h4D;  // 'M'
    localparam logic [7:0] CMD_SEL  = 8'h53;  // 'S'
    localparam logic [7:0] CMD_UP   = 8'h55;  // 'U'
    localparam logic [7:0] CMD_DN   = 8'h44;  // 'D'

    localparam int unsigned RPT_DLY_DEFAULT = 50_000_000;
    localparam int unsigned RPT_PER_DEFAULT = 10_000_000;

    // Commands are upper-case letters; OR-ing 0x20 gives the lower-case form.
    function automatic logic is_cmd(input logic [7:0] data, input logic [7:0] cmd);
        return (data == cmd) || (data == (cmd | 8'h20));
    endfunction

endpackage

// File: rtl/wtch_rpt_pulse.sv
// Rising-edge pulse generator for one up/dn button, gated by an enable.
// With WTCH_CTRL_AUTOREPEAT_EN defined, a held button also repeats after REPEAT_DLY, then every REPEAT_PER.
module wtch_rpt_pulse
    import wtch_ctrl_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = RPT_DLY_DEFAULT,
    parameter int unsigned REPEAT_PER = RPT_PER_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    input  logic en_i,
    output logic pulse_o
);

    logic prev_q;
    logic edge_w;

    // Previous level resets high so a button held through reset gives no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= lvl_i;
        end
    end

    assign edge_w = lvl_i & ~prev_q;

`ifdef WTCH_CTRL_AUTOREPEAT_EN
    localparam int unsigned CW = $clog2(REPEAT_DLY + 1);
    localparam logic [CW-1:0] CNT_FIRE   = CW'(REPEAT_DLY);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(REPEAT_DLY - REPEAT_PER + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          fire_w;

    assign fire_w = (cnt_q == CNT_FIRE);

    // The counter only runs once an edge was seen in the enabled state; zero means idle.
    always_comb begin
        cnt_d = '0;
        if (en_i && lvl_i) begin
            if (fire_w) begin
                cnt_d = CNT_RELOAD;
            end else if (edge_w || (cnt_q != '0)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse_o = en_i & (edge_w | (lvl_i & fire_w));
`else
    localparam int unsigned unused_rpt_cfg = REPEAT_DLY + REPEAT_PER;

    assign pulse_o = en_i & edge_w;
`endif

endmodule

// File: rtl/wtch_ctrl_fsm.sv
// Watch mode/calibration controller: RUN/STOP/CALIB FSM driven by buttons and UART commands.
// Build option: WTCH_CTRL_AUTOREPEAT_EN adds auto-repeat of held up/dn buttons in CALIB.
module wtch_ctrl_fsm
    import wtch_ctrl_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = RPT_DLY_DEFAULT,
    parameter int unsigned REPEAT_PER = RPT_PER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_run,
    input  logic       i_btn_mode,
    input  logic       i_btn_sel,
    input  logic       i_btn_up,
    input  logic       i_btn_dn,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_run,
    output logic       o_up,
    output logic       o_dn,
    output logic       o_fmt_mode,
    output logic       o_calib_right,
    output logic [1:0] o_state
);

    state_e     state_q, state_d;
    logic       run_q, run_d;
    logic       up_q, up_d;
    logic       dn_q, dn_d;
    logic       fmt_q, fmt_d;
    logic       cr_q, cr_d;
    logic [2:0] prev_q;
    logic       calib_en_w, up_pulse_w, dn_pulse_w, both_held_w;
    logic       run_ev_w, mode_ev_w, sel_ev_w, up_ev_w, dn_ev_w;

    assign calib_en_w = (state_q == ST_CALIB);

    wtch_rpt_pulse #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_up_pulse (
        .clk(clk), .rst(rst), .lvl_i(i_btn_up), .en_i(calib_en_w), .pulse_o(up_pulse_w)
    );

    wtch_rpt_pulse #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_dn_pulse (
        .clk(clk), .rst(rst), .lvl_i(i_btn_dn), .en_i(calib_en_w), .pulse_o(dn_pulse_w)
    );

`ifdef WTCH_CTRL_AUTOREPEAT_EN
    assign both_held_w = i_btn_up & i_btn_dn;
`else
    assign both_held_w = 1'b0;
`endif

    // i_rx_valid is a one-cycle strobe with no ready: every qualified byte is consumed that cycle.
    assign run_ev_w  = (i_btn_run  & ~prev_q[2]) | (i_rx_valid & is_cmd(i_rx_data, CMD_RUN));
    assign mode_ev_w = (i_btn_mode & ~prev_q[1]) | (i_rx_valid & is_cmd(i_rx_data, CMD_MODE));
    assign sel_ev_w  = (i_btn_sel  & ~prev_q[0]) | (i_rx_valid & is_cmd(i_rx_data, CMD_SEL));
    assign up_ev_w   = (up_pulse_w & ~both_held_w) | (i_rx_valid & is_cmd(i_rx_data, CMD_UP));
    assign dn_ev_w   = (dn_pulse_w & ~both_held_w) | (i_rx_valid & is_cmd(i_rx_data, CMD_DN));

    always_comb begin
        state_d = state_q;
        cr_d    = cr_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        fmt_d   = fmt_q ^ mode_ev_w;
        case (state_q)
            ST_RUN: begin
                if (run_ev_w) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (run_ev_w) begin
                    state_d = ST_RUN;
                end else if (sel_ev_w) begin
                    state_d = ST_CALIB;
                    cr_d    = 1'b0;
                end
            end
            ST_CALIB: begin
                if (run_ev_w) begin
                    state_d = ST_RUN;
                end else begin
                    if (sel_ev_w) cr_d = ~cr_q;
                    // Opposite requests cancel; back-to-back pulses are suppressed.
                    up_d = up_ev_w & ~dn_ev_w & ~up_q;
                    dn_d = dn_ev_w & ~up_ev_w & ~dn_q;
                end
            end
            default: state_d = ST_STOP;
        endcase
        run_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            fmt_q   <= 1'b0;
            cr_q    <= 1'b0;
            prev_q  <= 3'b111;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            fmt_q   <= fmt_d;
            cr_q    <= cr_d;
            prev_q  <= {i_btn_run, i_btn_mode, i_btn_sel};
        end
    end

    assign o_state       = state_q;
    assign o_run         = run_q;
    assign o_up          = up_q;
    assign o_dn          = dn_q;
    assign o_fmt_mode    = fmt_q;
    assign o_calib_right = cr_q;

endmodule

// File: tb/tb_wtch_ctrl_fsm.sv
// Self-checking bench for wtch_ctrl_fsm: directed steps plus random buttons/UART bytes,
// compared each cycle against a behavioural model of the controller rules.
module tb_wtch_ctrl_fsm;

  localparam int DLY = 20;
  localparam int PER = 5;
`ifdef WTCH_CTRL_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       i_btn_run, i_btn_mode, i_btn_sel, i_btn_up, i_btn_dn;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       o_run, o_up, o_dn, o_fmt_mode, o_calib_right;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  wtch_ctrl_fsm #(.REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .clk(clk), .rst(rst),
    .i_btn_run(i_btn_run), .i_btn_mode(i_btn_mode), .i_btn_sel(i_btn_sel),
    .i_btn_up(i_btn_up), .i_btn_dn(i_btn_dn),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_run(o_run), .o_up(o_up), .o_dn(o_dn),
    .o_fmt_mode(o_fmt_mode), .o_calib_right(o_calib_right), .o_state(o_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // Button vector order: {run, mode, sel, up, dn}; m_state: 0 running, 1 stopped, 2 calibrating.
  logic [7:0] cmd_chr [5] = '{8'h44, 8'h55, 8'h53, 8'h4D, 8'h52};
  logic [7:0] rx_tbl [12] = '{8'h52, 8'h72, 8'h4D, 8'h6D, 8'h53, 8'h73,
                              8'h55, 8'h75, 8'h44, 8'h64, 8'h78, 8'h41};
  int         m_state;
  logic       m_run, m_up, m_dn, m_fmt, m_cr;
  logic [4:0] m_prev;
  int         m_hold [2];

  function automatic logic [7:0] upcase(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
    return c;
  endfunction

  task automatic model_reset();
    m_state = 0; m_run = 1'b1; m_up = 1'b0; m_dn = 1'b0;
    m_fmt = 1'b0; m_cr = 1'b0; m_prev = 5'h1F;
    m_hold[0] = -1; m_hold[1] = -1;
  endtask

  task automatic model_clock(input logic [4:0] btn, input logic [7:0] d, input logic v);
    logic [4:0] ev;
    logic [1:0] fire;
    logic       ev_up, ev_dn, nu, nd;
    for (int i = 0; i < 5; i++)
      ev[i] = (btn[i] && !m_prev[i]) || (v && upcase(d) == cmd_chr[i]);
    // m_hold counts cycles since a calibrating-state press of a still-held up/dn button.
    for (int k = 0; k < 2; k++) begin
      if (!btn[k] || m_state != 2) m_hold[k] = -1;
      else if (!m_prev[k]) m_hold[k] = 0;
      else if (m_hold[k] >= 0) m_hold[k]++;
      fire[k] = (m_hold[k] == 0) ||
                (AUTOREP && m_hold[k] >= DLY && ((m_hold[k] - DLY) % PER) == 0);
    end
    if (AUTOREP && btn[1] && btn[0]) fire = 2'b00;
    ev_up = fire[1] || ev[1] && v && upcase(d) == 8'h55;
    ev_dn = fire[0] || ev[0] && v && upcase(d) == 8'h44;
    if (ev[3]) m_fmt = !m_fmt;
    nu = 1'b0; nd = 1'b0;
    if (ev[4]) m_state = (m_state == 0) ? 1 : 0;
    else if (m_state == 1 && ev[2]) begin m_state = 2; m_cr = 1'b0; end
    else if (m_state == 2) begin
      if (ev[2]) m_cr = !m_cr;
      if (ev_up != ev_dn) begin
        nu = ev_up && !m_up;
        nd = ev_dn && !m_dn;
      end
    end
    m_up = nu; m_dn = nd;
    m_run = (m_state == 0);
    m_prev = btn;
  endtask

  // ---------------- scoreboard / checks ----------------
  task automatic compare(input string tag);
    logic [6:0] obs, exp;
    obs = {o_state, o_run, o_up, o_dn, o_fmt_mode, o_calib_right};
    exp = {2'(m_state), m_run, m_up, m_dn, m_fmt, m_cr};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed {st,run,up,dn,fmt,cr}=%b expected %b", tag, obs, exp);
    end
    vectors++;
    assert (!(o_up === 1'b1 && o_dn === 1'b1)) else begin
      miscompares++;
      $error("FAIL %s_updn_excl: observed up=%b dn=%b expected not both high", tag, o_up, o_dn);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [4:0] btn, input logic [7:0] d, input logic v, input string tag);
    {i_btn_run, i_btn_mode, i_btn_sel, i_btn_up, i_btn_dn} = btn;
    i_rx_data = d;
    i_rx_valid = v;
    @(posedge clk);
    model_clock(btn, d, v);
    #1;
    compare(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [4:0] btn;
    int         dn_pulses;

    rst = 1'b1;
    {i_btn_run, i_btn_mode, i_btn_sel, i_btn_up, i_btn_dn} = 5'b00010;
    i_rx_data = 8'h00;
    i_rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare("reset_values");
    check("reset_state", o_state, 0);
    check("reset_run", o_run, 1);
    rst = 1'b0;

    repeat (3) step(5'b00010, 8'h00, 1'b0, "up_held_through_reset");
    check("no_up_after_reset", o_up, 0);
    step(5'b00000, 8'h00, 1'b0, "release");

    step(5'b10000, 8'h00, 1'b0, "run_to_stop");
    check("stop_state", o_state, 1);
    step(5'b00000, 8'h00, 1'b0, "idle");
    step(5'b00100, 8'h00, 1'b0, "sel_to_calib");
    check("calib_state", o_state, 2);
    check("calib_right_cleared", o_calib_right, 0);
    step(5'b00000, 8'h00, 1'b0, "idle");
    step(5'b00010, 8'h00, 1'b0, "up_edge");
    check("up_pulse", o_up, 1);
    step(5'b00010, 8'h00, 1'b0, "up_held");
    check("up_single", o_up, 0);

    step(5'b00000, 8'h00, 1'b0, "idle");
    step(5'b00010, 8'h64, 1'b1, "uart_d_with_up_cancel");
    check("cancel_up", o_up, 0);
    check("cancel_dn", o_dn, 0);
    step(5'b00000, 8'h64, 1'b1, "uart_d");
    check("uart_dn_pulse", o_dn, 1);
    step(5'b00000, 8'h53, 1'b1, "uart_S");
    check("calib_right_set", o_calib_right, 1);
    step(5'b00000, 8'h78, 1'b1, "uart_junk");
    step(5'b00000, 8'h75, 1'b1, "uart_u_first");
    step(5'b00000, 8'h75, 1'b1, "uart_u_back_to_back");
    check("no_consecutive_up", o_up, 0);

    step(5'b10000, 8'h00, 1'b0, "calib_to_run");
    step(5'b00000, 8'h00, 1'b0, "idle");
    step(5'b10000, 8'h00, 1'b0, "run_to_stop2");
    step(5'b00000, 8'h00, 1'b0, "idle");
    step(5'b10100, 8'h00, 1'b0, "run_and_sel_in_stop");
    check("run_wins_state", o_state, 0);
    check("run_wins_cr", o_calib_right, 1);
    step(5'b00000, 8'h00, 1'b0, "idle");
    step(5'b01000, 8'h00, 1'b0, "mode_in_run");
    check("fmt_toggled", o_fmt_mode, 1);
    step(5'b00000, 8'h00, 1'b0, "idle");
    step(5'b01000, 8'h4D, 1'b1, "mode_btn_and_uart_once");
    check("fmt_once", o_fmt_mode, 0);

    // Hold dn in calibration long enough for several repeats when auto-repeat is built in.
    step(5'b10000, 8'h00, 1'b0, "to_stop");
    step(5'b00000, 8'h00, 1'b0, "idle");
    step(5'b00100, 8'h00, 1'b0, "to_calib");
    step(5'b00000, 8'h00, 1'b0, "idle");
    dn_pulses = 0;
    for (int i = 0; i < 33; i++) begin
      step(5'b00001, 8'h00, 1'b0, "hold_dn");
      if (o_dn === 1'b1) dn_pulses++;
    end
    step(5'b00000, 8'h00, 1'b0, "release_dn");
    check("hold_dn_pulse_count", dn_pulses, AUTOREP ? 4 : 1);
    repeat (3) step(5'b00000, 8'h00, 1'b0, "after_release");

    // Asynchronous reset in the middle of a held up press.
    step(5'b00010, 8'h00, 1'b0, "up_edge_pre_reset");
    step(5'b00010, 8'h00, 1'b0, "up_hold_pre_reset");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare("async_reset_mid_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) step(5'b00010, 8'h00, 1'b0, "up_held_after_reset");
    check("no_pulse_after_reset", o_up, 0);

    // Random phase: sparse button toggles and UART bytes from a mixed command table.
    btn = 5'b00000;
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      logic       v;
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
      v = ($urandom_range(0, 3) == 0);
      d = rx_tbl[$urandom_range(0, 11)];
      step(btn, d, v, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
